// File: rtl/reu_reg_mc_if.sv
// ---------------------------------------------------------------------------
// reu_reg_mc_if
// 6502-side register window bus for the multi-channel REU register file.
//   RegRD : register read strobe (one PHI2 cycle)
//   RegWR : register write strobe (one PHI2 cycle)
//   A     : register address, A[AW-1:4] = channel, A[3:0] = register
//   WRD   : write data
//   RDD   : read data, combinational from A
// The CPU side uses the master modport; the register file uses slave.
// ---------------------------------------------------------------------------
interface reu_reg_mc_if #(
    parameter int AW = 5
);
    logic          RegRD;
    logic          RegWR;
    logic [AW-1:0] A;
    logic [7:0]    WRD;
    logic [7:0]    RDD;

    modport master (
        output RegRD,
        output RegWR,
        output A,
        output WRD,
        input  RDD
    );

    modport slave (
        input  RegRD,
        input  RegWR,
        input  A,
        input  WRD,
        output RDD
    );
endinterface

// File: rtl/reu_reg_mc.sv
// ---------------------------------------------------------------------------
// reu_reg_mc
// Multi-channel REU DMA register file. Holds NCH independent channel register
// sets behind the 6502 register window and exposes the registers of the
// channel currently owned by the transfer sequencer.
//
// Ports:
//   PHI2          : system clock, all state changes on the falling edge
//   Reset         : synchronous active-high reset
//   bus           : register window (RegRD, RegWR, A, WRD, RDD)
//   ActCh         : channel owned by the sequencer
//   NextCA        : C64-side byte done on ActCh
//   NextREUA      : REU-side byte done on ActCh
//   VerifyErr     : verify mismatch on ActCh
//   XferEnd       : transfer complete on ActCh
//   IRQOut        : registered OR of the per-channel interrupt requests
//   ExecuteENOut  : per-channel execute bit
//   FF00DecodeEN  : per-channel FF00 trigger armed
//   XferTypeOut   : transfer type of ActCh
//   CAOut         : C64 address of ActCh
//   REUAOut       : REU address of ActCh (bits above REUA_W as written)
//   Length1       : Length of ActCh equals 1
// ---------------------------------------------------------------------------
module reu_reg_mc #(
    parameter int NCH    = 2,
    parameter int CHB    = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int REUA_W = 19,
    parameter int AW     = 4 + CHB
) (
    input  logic           PHI2,
    input  logic           Reset,
    reu_reg_mc_if.slave    bus,
    input  logic [CHB-1:0] ActCh,
    input  logic           NextCA,
    input  logic           NextREUA,
    input  logic           VerifyErr,
    input  logic           XferEnd,
    output logic           IRQOut,
    output logic [NCH-1:0] ExecuteENOut,
    output logic [NCH-1:0] FF00DecodeEN,
    output logic [1:0]     XferTypeOut,
    output logic [15:0]    CAOut,
    output logic [23:0]    REUAOut,
    output logic           Length1
);

    localparam logic [3:0] REG_STATUS  = 4'h0;
    localparam logic [3:0] REG_CMD     = 4'h1;
    localparam logic [3:0] REG_CALO    = 4'h2;
    localparam logic [3:0] REG_CAHI    = 4'h3;
    localparam logic [3:0] REG_REUALO  = 4'h4;
    localparam logic [3:0] REG_REUAMID = 4'h5;
    localparam logic [3:0] REG_REUAHI  = 4'h6;
    localparam logic [3:0] REG_LENLO   = 4'h7;
    localparam logic [3:0] REG_LENHI   = 4'h8;
    localparam logic [3:0] REG_IMASK   = 4'h9;
    localparam logic [3:0] REG_ADDRCTL = 4'hA;

    // One bit per decodable channel slot; slots at or above NCH are absent.
    localparam int NSLOT = 1 << CHB;
    localparam logic [NSLOT-1:0] CH_EXISTS = {NSLOT{1'b1}} >> (NSLOT - NCH);

    // Mask of the REU address bits above REUA_W: these bits never count,
    // are not autoloaded, and read back as 1.
    localparam logic [23:0] REUA_HI_ONES = ~((24'd1 << REUA_W) - 24'd1);

    // Increment the implemented REU address bits, wrapping at 2^REUA_W and
    // leaving the unimplemented upper bits untouched.
    function automatic logic [23:0] reuaIncr(input logic [23:0] v);
        logic [23:0] sum;
        sum      = v + 24'd1;
        reuaIncr = (v & REUA_HI_ONES) | (sum & ~REUA_HI_ONES);
    endfunction

    // Reload only the implemented bits from the shadow.
    function automatic logic [23:0] reuaReload(input logic [23:0] live, input logic [23:0] shadow);
        reuaReload = (live & REUA_HI_ONES) | (shadow & ~REUA_HI_ONES);
    endfunction

    // Per-channel state
    logic [NCH-1:0] intPending_r;
    logic [NCH-1:0] endOfBlock_r;
    logic [NCH-1:0] fault_r;
    logic [NCH-1:0] sizeBit_r;
    logic [NCH-1:0] executeEn_r;
    logic [NCH-1:0] ff00En_r;
    logic [NCH-1:0] autoloadEn_r;
    logic [NCH-1:0] intEn_r;
    logic [NCH-1:0] eobMask_r;
    logic [NCH-1:0] verMask_r;
    logic [1:0]     xferType_r   [NCH];
    logic [1:0]     incMode_r    [NCH];
    logic [15:0]    ca_r         [NCH];
    logic [15:0]    caShadow_r   [NCH];
    logic [23:0]    reua_r       [NCH];
    logic [23:0]    reuaShadow_r [NCH];
    logic [15:0]    len_r        [NCH];
    logic [15:0]    lenShadow_r  [NCH];
    logic           irqOut_r;

    // Decode
    logic [CHB-1:0] regCh_s;
    logic [3:0]     regSel_s;
    logic           regChValid_s;
    logic           actValid_s;
    logic [NCH-1:0] wrCh_s;
    logic [NCH-1:0] rdStat_s;
    logic [NCH-1:0] seqCh_s;
    logic [NCH-1:0] xferEndCh_s;
    logic [NCH-1:0] verErrCh_s;
    logic [NCH-1:0] autoload_s;
    logic [NCH-1:0] incCa_s;
    logic [NCH-1:0] incReua_s;
    logic [NCH-1:0] decLen_s;
    logic [NCH-1:0] irq_s;
    logic [7:0]     rdData_s;
    logic [23:0]    reuaRd_s;
    logic [1:0]     xferTypeAct_s;
    logic [15:0]    caAct_s;
    logic [23:0]    reuaAct_s;
    logic           length1Act_s;

    assign regCh_s      = bus.A[AW-1:4];
    assign regSel_s     = bus.A[3:0];
    assign regChValid_s = CH_EXISTS[regCh_s];
    assign actValid_s   = CH_EXISTS[ActCh];

    // Per-channel host strobes and sequencer event qualification
    always_comb begin
        wrCh_s      = {NCH{1'b0}};
        rdStat_s    = {NCH{1'b0}};
        seqCh_s     = {NCH{1'b0}};
        xferEndCh_s = {NCH{1'b0}};
        verErrCh_s  = {NCH{1'b0}};
        autoload_s  = {NCH{1'b0}};
        incCa_s     = {NCH{1'b0}};
        incReua_s   = {NCH{1'b0}};
        decLen_s    = {NCH{1'b0}};
        for (int ch = 0; ch < NCH; ch++) begin
            wrCh_s[ch]      = bus.RegWR && regChValid_s && (regCh_s == CHB'(ch));
            rdStat_s[ch]    = bus.RegRD && regChValid_s && (regCh_s == CHB'(ch))
                              && (regSel_s == REG_STATUS);
            seqCh_s[ch]     = actValid_s && (ActCh == CHB'(ch));
            xferEndCh_s[ch] = seqCh_s[ch] && XferEnd;
            verErrCh_s[ch]  = seqCh_s[ch] && VerifyErr;
            autoload_s[ch]  = autoloadEn_r[ch] && seqCh_s[ch] && XferEnd;
            incCa_s[ch]     = seqCh_s[ch] && NextCA && !incMode_r[ch][1];
            incReua_s[ch]   = seqCh_s[ch] && NextREUA && !incMode_r[ch][0];
            // Length parks at 1 so the sequencer sees the last byte stably
            decLen_s[ch]    = seqCh_s[ch] && NextCA && (len_r[ch] != 16'h0001);
        end
    end

    // Channel register state: reset, host writes, autoload, sequencer counting
    always_ff @(negedge PHI2) begin
        if (Reset) begin
            intPending_r <= {NCH{1'b0}};
            endOfBlock_r <= {NCH{1'b0}};
            fault_r      <= {NCH{1'b0}};
            sizeBit_r    <= {NCH{1'b0}};
            executeEn_r  <= {NCH{1'b0}};
            ff00En_r     <= {NCH{1'b0}};
            autoloadEn_r <= {NCH{1'b0}};
            intEn_r      <= {NCH{1'b0}};
            eobMask_r    <= {NCH{1'b0}};
            verMask_r    <= {NCH{1'b0}};
            for (int ch = 0; ch < NCH; ch++) begin
                xferType_r[ch]   <= 2'b00;
                incMode_r[ch]    <= 2'b00;
                ca_r[ch]         <= 16'h0000;
                caShadow_r[ch]   <= 16'h0000;
                reua_r[ch]       <= 24'h000000;
                reuaShadow_r[ch] <= 24'h000000;
                len_r[ch]        <= 16'hFFFF;
                lenShadow_r[ch]  <= 16'hFFFF;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                // Status flags: a set event in the same cycle beats the read-clear
                if (xferEndCh_s[ch] || verErrCh_s[ch]) begin
                    intPending_r[ch] <= 1'b1;
                end else if (rdStat_s[ch]) begin
                    intPending_r[ch] <= 1'b0;
                end
                if (xferEndCh_s[ch]) begin
                    endOfBlock_r[ch] <= 1'b1;
                end else if (rdStat_s[ch]) begin
                    endOfBlock_r[ch] <= 1'b0;
                end
                if (verErrCh_s[ch]) begin
                    fault_r[ch] <= 1'b1;
                end else if (rdStat_s[ch]) begin
                    fault_r[ch] <= 1'b0;
                end

                if (wrCh_s[ch] && (regSel_s == REG_STATUS)) begin
                    sizeBit_r[ch] <= bus.WRD[4];
                end

                // Command: host write beats the end-of-transfer disarm
                if (wrCh_s[ch] && (regSel_s == REG_CMD)) begin
                    executeEn_r[ch]  <= bus.WRD[7];
                    autoloadEn_r[ch] <= bus.WRD[5];
                    ff00En_r[ch]     <= ~bus.WRD[4];
                    xferType_r[ch]   <= bus.WRD[1:0];
                end else if (xferEndCh_s[ch] || verErrCh_s[ch]) begin
                    executeEn_r[ch] <= 1'b0;
                    ff00En_r[ch]    <= 1'b0;
                end

                if (wrCh_s[ch] && (regSel_s == REG_IMASK)) begin
                    intEn_r[ch]   <= bus.WRD[7];
                    eobMask_r[ch] <= bus.WRD[6];
                    verMask_r[ch] <= bus.WRD[5];
                end

                if (wrCh_s[ch] && (regSel_s == REG_ADDRCTL)) begin
                    incMode_r[ch] <= bus.WRD[7:6];
                end

                // C64 address: a byte write drops any same-cycle increment
                if (wrCh_s[ch] && (regSel_s == REG_CALO)) begin
                    ca_r[ch][7:0]       <= bus.WRD;
                    caShadow_r[ch][7:0] <= bus.WRD;
                end else if (wrCh_s[ch] && (regSel_s == REG_CAHI)) begin
                    ca_r[ch][15:8]       <= bus.WRD;
                    caShadow_r[ch][15:8] <= bus.WRD;
                end else if (autoload_s[ch]) begin
                    ca_r[ch] <= caShadow_r[ch];
                end else if (incCa_s[ch]) begin
                    ca_r[ch] <= ca_r[ch] + 16'd1;
                end

                // REU address
                if (wrCh_s[ch] && (regSel_s == REG_REUALO)) begin
                    reua_r[ch][7:0]       <= bus.WRD;
                    reuaShadow_r[ch][7:0] <= bus.WRD;
                end else if (wrCh_s[ch] && (regSel_s == REG_REUAMID)) begin
                    reua_r[ch][15:8]       <= bus.WRD;
                    reuaShadow_r[ch][15:8] <= bus.WRD;
                end else if (wrCh_s[ch] && (regSel_s == REG_REUAHI)) begin
                    reua_r[ch][23:16]       <= bus.WRD;
                    reuaShadow_r[ch][23:16] <= bus.WRD;
                end else if (autoload_s[ch]) begin
                    reua_r[ch] <= reuaReload(reua_r[ch], reuaShadow_r[ch]);
                end else if (incReua_s[ch]) begin
                    reua_r[ch] <= reuaIncr(reua_r[ch]);
                end

                // Length: 0x0000 means 65536 and simply decrements to 0xFFFF
                if (wrCh_s[ch] && (regSel_s == REG_LENLO)) begin
                    len_r[ch][7:0]       <= bus.WRD;
                    lenShadow_r[ch][7:0] <= bus.WRD;
                end else if (wrCh_s[ch] && (regSel_s == REG_LENHI)) begin
                    len_r[ch][15:8]       <= bus.WRD;
                    lenShadow_r[ch][15:8] <= bus.WRD;
                end else if (autoload_s[ch]) begin
                    len_r[ch] <= lenShadow_r[ch];
                end else if (decLen_s[ch]) begin
                    len_r[ch] <= len_r[ch] - 16'd1;
                end
            end
        end
    end

    // Per-channel interrupt request; Fault is latched so the request holds
    assign irq_s = intEn_r & ((endOfBlock_r & eobMask_r) | (fault_r & verMask_r));

    // Merged interrupt output register
    always_ff @(negedge PHI2) begin
        if (Reset) begin
            irqOut_r <= 1'b0;
        end else begin
            irqOut_r <= |irq_s;
        end
    end

    // Register window read mux; absent channels and unused registers read 0xFF
    always_comb begin
        rdData_s = 8'hFF;
        reuaRd_s = reua_r[regCh_s] | REUA_HI_ONES;
        if (regChValid_s) begin
            case (regSel_s)
                REG_STATUS:  rdData_s = {intPending_r[regCh_s], endOfBlock_r[regCh_s],
                                         fault_r[regCh_s], sizeBit_r[regCh_s], 4'b0000};
                REG_CMD:     rdData_s = {executeEn_r[regCh_s], 1'b0, autoloadEn_r[regCh_s],
                                         ~ff00En_r[regCh_s], 2'b00, xferType_r[regCh_s]};
                REG_CALO:    rdData_s = ca_r[regCh_s][7:0];
                REG_CAHI:    rdData_s = ca_r[regCh_s][15:8];
                REG_REUALO:  rdData_s = reuaRd_s[7:0];
                REG_REUAMID: rdData_s = reuaRd_s[15:8];
                REG_REUAHI:  rdData_s = reuaRd_s[23:16];
                REG_LENLO:   rdData_s = len_r[regCh_s][7:0];
                REG_LENHI:   rdData_s = len_r[regCh_s][15:8];
                REG_IMASK:   rdData_s = {intEn_r[regCh_s], eobMask_r[regCh_s],
                                         verMask_r[regCh_s], 5'b11111};
                REG_ADDRCTL: rdData_s = {incMode_r[regCh_s], 6'b111111};
                default:     rdData_s = 8'hFF;
            endcase
        end else begin
            rdData_s = 8'hFF;
        end
    end

    // Active-channel view for the transfer sequencer
    always_comb begin
        xferTypeAct_s = 2'b00;
        caAct_s       = 16'h0000;
        reuaAct_s     = 24'h000000;
        length1Act_s  = 1'b0;
        if (actValid_s) begin
            xferTypeAct_s = xferType_r[ActCh];
            caAct_s       = ca_r[ActCh];
            reuaAct_s     = reua_r[ActCh];
            length1Act_s  = (len_r[ActCh] == 16'h0001);
        end else begin
            xferTypeAct_s = 2'b00;
            caAct_s       = 16'h0000;
            reuaAct_s     = 24'h000000;
            length1Act_s  = 1'b0;
        end
    end

    assign bus.RDD      = rdData_s;
    assign IRQOut       = irqOut_r;
    assign ExecuteENOut = executeEn_r;
    assign FF00DecodeEN = ff00En_r;
    assign XferTypeOut  = xferTypeAct_s;
    assign CAOut        = caAct_s;
    assign REUAOut      = reuaAct_s;
    assign Length1      = length1Act_s;

endmodule

// File: tb/tb_reu_reg_mc.sv
// ---------------------------------------------------------------------------
// tb_reu_reg_mc
// Directed bench for reu_reg_mc with NCH=2, REUA_W=19. Inputs change on the
// PHI2 rising edge; the DUT updates on the falling edge; outputs are checked
// on the rising edge (plus #1 for combinational read data).
// ---------------------------------------------------------------------------
module tb_reu_reg_mc;

    logic        PHI2 = 1'b0;
    logic        Reset;
    logic [0:0]  ActCh;
    logic        NextCA;
    logic        NextREUA;
    logic        VerifyErr;
    logic        XferEnd;
    logic        IRQOut;
    logic [1:0]  ExecuteENOut;
    logic [1:0]  FF00DecodeEN;
    logic [1:0]  XferTypeOut;
    logic [15:0] CAOut;
    logic [23:0] REUAOut;
    logic        Length1;

    int total = 0;
    int bad   = 0;

    reu_reg_mc_if #(.AW(5)) bus ();

    reu_reg_mc #(
        .NCH    (2),
        .REUA_W (19)
    ) dut (
        .PHI2         (PHI2),
        .Reset        (Reset),
        .bus          (bus),
        .ActCh        (ActCh),
        .NextCA       (NextCA),
        .NextREUA     (NextREUA),
        .VerifyErr    (VerifyErr),
        .XferEnd      (XferEnd),
        .IRQOut       (IRQOut),
        .ExecuteENOut (ExecuteENOut),
        .FF00DecodeEN (FF00DecodeEN),
        .XferTypeOut  (XferTypeOut),
        .CAOut        (CAOut),
        .REUAOut      (REUAOut),
        .Length1      (Length1)
    );

    always #5 PHI2 = ~PHI2;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic regWrite(input logic [4:0] addr, input logic [7:0] data);
        @(posedge PHI2);
        bus.A     = addr;
        bus.WRD   = data;
        bus.RegWR = 1'b1;
        @(posedge PHI2);
        bus.RegWR = 1'b0;
    endtask

    task automatic readChk(input string tag, input logic [4:0] addr, input logic [7:0] exp);
        @(posedge PHI2);
        bus.A = addr;
        #1;
        checkVal(tag, {24'h0, bus.RDD}, {24'h0, exp});
    endtask

    // Status read with the clearing strobe; data shows pre-edge flags
    task automatic statusRead(input string tag, input logic [4:0] addr, input logic [7:0] exp);
        @(posedge PHI2);
        bus.A     = addr;
        bus.RegRD = 1'b1;
        #1;
        checkVal(tag, {24'h0, bus.RDD}, {24'h0, exp});
        @(posedge PHI2);
        bus.RegRD = 1'b0;
    endtask

    task automatic pulseSeq(input logic nca, input logic nreua, input logic verr, input logic xend);
        @(posedge PHI2);
        NextCA    = nca;
        NextREUA  = nreua;
        VerifyErr = verr;
        XferEnd   = xend;
        @(posedge PHI2);
        NextCA    = 1'b0;
        NextREUA  = 1'b0;
        VerifyErr = 1'b0;
        XferEnd   = 1'b0;
    endtask

    initial begin
        Reset     = 1'b1;
        ActCh     = 1'b0;
        NextCA    = 1'b0;
        NextREUA  = 1'b0;
        VerifyErr = 1'b0;
        XferEnd   = 1'b0;
        bus.RegRD = 1'b0;
        bus.RegWR = 1'b0;
        bus.A     = 5'h00;
        bus.WRD   = 8'h00;
        repeat (3) @(posedge PHI2);
        Reset = 1'b0;

        // Reset state
        readChk("rst_len_lo", 5'h07, 8'hFF);
        readChk("rst_len_hi", 5'h08, 8'hFF);
        readChk("rst_reua_hi", 5'h06, 8'hF8);
        readChk("rst_status", 5'h00, 8'h00);
        readChk("rst_cmd", 5'h01, 8'h10);
        readChk("rst_imask", 5'h09, 8'h1F);
        readChk("rst_addrctl", 5'h0A, 8'h3F);
        readChk("rst_unused", 5'h1B, 8'hFF);
        checkVal("rst_irq", {31'h0, IRQOut}, 32'h0);
        checkVal("rst_exec", {30'h0, ExecuteENOut}, 32'h0);
        checkVal("rst_ff00", {30'h0, FF00DecodeEN}, 32'h0);
        checkVal("rst_ca", {16'h0, CAOut}, 32'h0);

        // Channel 1 counting across byte and REU wrap boundaries
        ActCh = 1'b1;
        regWrite(5'h12, 8'hFF);
        regWrite(5'h13, 8'h12);
        regWrite(5'h14, 8'hFF);
        regWrite(5'h15, 8'hFF);
        regWrite(5'h16, 8'h07);
        regWrite(5'h17, 8'h02);
        regWrite(5'h18, 8'h00);
        checkVal("c1_ca_init", {16'h0, CAOut}, 32'h12FF);
        checkVal("c1_reua_init", {8'h0, REUAOut}, 32'h07FFFF);
        checkVal("c1_len1_init", {31'h0, Length1}, 32'h0);
        pulseSeq(1'b1, 1'b1, 1'b0, 1'b0);
        pulseSeq(1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("c1_ca", {16'h0, CAOut}, 32'h1301);
        checkVal("c1_reua", {8'h0, REUAOut}, 32'h000001);
        checkVal("c1_len1", {31'h0, Length1}, 32'h1);
        readChk("c1_len_lo", 5'h17, 8'h01);
        readChk("c1_len_hi", 5'h18, 8'h00);
        readChk("c1_reua_hi_rd", 5'h16, 8'hF8);
        readChk("c0_ca_lo_kept", 5'h02, 8'h00);
        readChk("c0_len_lo_kept", 5'h07, 8'hFF);
        // Upper REU bits come from the written value and never count
        regWrite(5'h14, 8'hFF);
        regWrite(5'h15, 8'hFF);
        regWrite(5'h16, 8'hAF);
        readChk("c1_reua_hi_ones", 5'h16, 8'hFF);
        pulseSeq(1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("c1_reua_wrap", {8'h0, REUAOut}, 32'hA80000);
        checkVal("c1_ca_hold", {16'h0, CAOut}, 32'h1301);
        checkVal("c1_len1_hold", {31'h0, Length1}, 32'h1);

        // Channel 0 with both address increments disabled
        ActCh = 1'b0;
        regWrite(5'h0A, 8'hC0);
        readChk("c0_addrctl", 5'h0A, 8'hFF);
        regWrite(5'h02, 8'h34);
        regWrite(5'h03, 8'h12);
        regWrite(5'h04, 8'h56);
        for (int i = 0; i < 3; i++) begin
            pulseSeq(1'b1, 1'b1, 1'b0, 1'b0);
        end
        checkVal("fix_ca", {16'h0, CAOut}, 32'h1234);
        checkVal("fix_reua", {8'h0, REUAOut}, 32'h000056);
        readChk("fix_len_lo", 5'h07, 8'hFC);
        readChk("fix_len_hi", 5'h08, 8'hFF);

        // Autoload on transfer end
        regWrite(5'h0A, 8'h00);
        regWrite(5'h01, 8'hA0);
        readChk("al_cmd", 5'h01, 8'hA0);
        checkVal("al_exec_on", {30'h0, ExecuteENOut}, 32'h1);
        checkVal("al_ff00_on", {30'h0, FF00DecodeEN}, 32'h1);
        regWrite(5'h02, 8'h00);
        regWrite(5'h03, 8'h20);
        regWrite(5'h07, 8'h10);
        regWrite(5'h08, 8'h00);
        for (int i = 0; i < 5; i++) begin
            pulseSeq(1'b1, 1'b0, 1'b0, 1'b0);
        end
        checkVal("al_ca_run", {16'h0, CAOut}, 32'h2005);
        readChk("al_len_run", 5'h07, 8'h0B);
        pulseSeq(1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("al_ca", {16'h0, CAOut}, 32'h2000);
        readChk("al_len", 5'h07, 8'h10);
        checkVal("al_exec_off", {30'h0, ExecuteENOut}, 32'h0);
        checkVal("al_ff00_off", {30'h0, FF00DecodeEN}, 32'h0);
        readChk("al_cmd_after", 5'h01, 8'h30);
        readChk("al_status", 5'h00, 8'hC0);
        checkVal("al_irq_masked", {31'h0, IRQOut}, 32'h0);
        statusRead("al_status_clr", 5'h00, 8'hC0);
        readChk("al_status_empty", 5'h00, 8'h00);

        // Verify-error interrupt
        regWrite(5'h09, 8'hA0);
        readChk("irq_imask", 5'h09, 8'hBF);
        pulseSeq(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checkVal("irq_not_yet", {31'h0, IRQOut}, 32'h0);
        @(posedge PHI2);
        #1;
        checkVal("irq_set", {31'h0, IRQOut}, 32'h1);
        repeat (3) @(posedge PHI2);
        #1;
        checkVal("irq_held", {31'h0, IRQOut}, 32'h1);
        statusRead("irq_status", 5'h00, 8'hA0);
        #1;
        checkVal("irq_lag", {31'h0, IRQOut}, 32'h1);
        @(posedge PHI2);
        #1;
        checkVal("irq_cleared", {31'h0, IRQOut}, 32'h0);

        // Status read coincident with transfer end: set wins
        @(posedge PHI2);
        bus.A     = 5'h00;
        bus.RegRD = 1'b1;
        XferEnd   = 1'b1;
        #1;
        checkVal("coinc_rd", {24'h0, bus.RDD}, 32'h00);
        @(posedge PHI2);
        bus.RegRD = 1'b0;
        XferEnd   = 1'b0;
        readChk("coinc_after", 5'h00, 8'hC0);
        @(posedge PHI2);
        #1;
        checkVal("coinc_eob_nomask", {31'h0, IRQOut}, 32'h0);
        statusRead("coinc_clr", 5'h00, 8'hC0);

        // Length 0x0000 means 65536
        regWrite(5'h07, 8'h00);
        regWrite(5'h08, 8'h00);
        pulseSeq(1'b1, 1'b0, 1'b0, 1'b0);
        readChk("len0_lo", 5'h07, 8'hFF);
        readChk("len0_hi", 5'h08, 8'hFF);
        checkVal("len0_ca", {16'h0, CAOut}, 32'h2001);

        // Host write and increment in the same cycle: write wins on CA only
        @(posedge PHI2);
        bus.A     = 5'h02;
        bus.WRD   = 8'h55;
        bus.RegWR = 1'b1;
        NextCA    = 1'b1;
        @(posedge PHI2);
        bus.RegWR = 1'b0;
        NextCA    = 1'b0;
        checkVal("coll_ca", {16'h0, CAOut}, 32'h2055);
        readChk("coll_len", 5'h07, 8'hFE);
        readChk("c1_ca_lo_iso", 5'h12, 8'h01);
        readChk("c1_ca_hi_iso", 5'h13, 8'h13);

        // Reset mid-transfer with a pending IRQ and a sequencer strobe
        pulseSeq(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge PHI2);
        #1;
        checkVal("mid_irq_pre", {31'h0, IRQOut}, 32'h1);
        @(posedge PHI2);
        Reset  = 1'b1;
        NextCA = 1'b1;
        @(posedge PHI2);
        Reset  = 1'b0;
        NextCA = 1'b0;
        #1;
        checkVal("mid_irq", {31'h0, IRQOut}, 32'h0);
        checkVal("mid_ca", {16'h0, CAOut}, 32'h0);
        readChk("mid_len_lo", 5'h07, 8'hFF);
        readChk("mid_imask", 5'h09, 8'h1F);
        readChk("mid_c1_ca", 5'h12, 8'h00);
        readChk("mid_status", 5'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
